io_bus_arbiter: RTL
===================

Name: io_bus_arbiter

Overview:
- Shares the single byte-serial IO bridge between two CPU requesters: the instruction-fetch unit and the load/store unit.
- Each requester gets a simple req/ack port. The arbiter grants one requester at a time using round-robin priority and latches that requester's command.
- It drives the bridge's load/store/segment/address/data inputs and collects the read data returned on the bridge's ready pulses.
- It also guards each transaction with a timeout watchdog.

Parameters:
- TIMEOUT, 1024: cycles in a busy state without io_ready before the transaction is aborted; 0 disables the watchdog.
- TCW, 11: width of the timeout counter; must satisfy 2^TCW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  24  fetch address {segment, offset}
- f_ack  out  1  fetch done, one-cycle pulse
- f_rdata  out  32  fetched instruction, {first word, second word}
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_stack  in  1  1 = stack segment, 0 = data segment
- d_awb  in  1  address-width/byte qualifier, passed through to the bridge
- d_addr  in  24  data address
- d_wdata  in  16  store data
- d_ack  out  1  data done, one-cycle pulse
- d_rdata  out  16  load result
- err  out  1  timeout abort, one-cycle pulse coincident with the ack
- io_load, io_store, io_code_seg, io_data_seg, io_stack_seg, io_awb  out  1 each  bridge command
- io_addr  out  24  bridge address
- io_data  out  16  bridge write data
- io_ready  in  1  bridge ready pulse
- io_rdata  in  16  bridge read data, valid when io_ready = 1

Behaviour:
- Reset values:
  - All outputs are 0.
  - State = IDLE, last_grant = DATA (so fetch wins the first tie), beat = 0, timeout counter = 0.
- States: IDLE, FETCH, DATA, GAP.
- IDLE:
  - f_req only -> FETCH.
  - d_req only -> DATA.
  - Both -> grant the side opposite last_grant.
  - On grant: latch the address, d_we, d_stack, d_awb and d_wdata into command registers; update last_grant; clear beat and timeout counter.
- Command outputs are registered from the latched fields. They are asserted from the first cycle in FETCH/DATA.
  - FETCH: io_load = 1, io_code_seg = 1, io_awb = 0.
  - DATA: io_store = d_we, io_load = ~d_we, io_data_seg = ~d_stack, io_stack_seg = d_stack.
- Completion gating: io_load/io_store are ANDed combinationally with ~(io_ready & last_beat). This drops them in the same cycle as the final ready pulse, so the bridge cannot start a new header.
  - The rest of the command (segments, addr, data) is held until GAP.
- FETCH is 2 beats:
  - 1st io_ready: f_rdata[31:16] <= io_rdata, beat <= 1.
  - 2nd io_ready: f_rdata[15:0] <= io_rdata -> GAP.
- DATA is 1 beat:
  - Load: d_rdata <= io_rdata on io_ready.
  - Store: ignores io_rdata.
  - Either case -> GAP on io_ready.
- GAP lasts exactly 1 cycle:
  - All io_* outputs are 0.
  - The granted side's ack = 1 for this cycle; err = 1 here if the transaction was aborted.
  - No arbitration occurs in GAP; next state is always IDLE.
  - The requester must drop req by the cycle after its ack. A req still high in IDLE is treated as a new request.
- Latency with an idle bus and a zero-wait bridge: the ack appears one cycle after the final io_ready.
- Timeout:
  - The counter increments every cycle in FETCH/DATA and clears on each io_ready.
  - When it reaches TIMEOUT: drop io_load/io_store, -> GAP with err = 1. Read data registers keep their prior contents.
  - The bridge may be left mid-transfer; recovery is a system reset.
- f_rdata and d_rdata hold their value until overwritten.
- A requester dropping req mid-transaction is ignored; the transaction runs to completion and still acks.
- io_ready seen in IDLE or GAP is ignored.
- If io_ready arrives in the same cycle the timeout counter reaches TIMEOUT, io_ready wins and the transaction completes normally.
- Asynchronous reset mid-transaction returns to IDLE immediately. No ack is issued.

Test Plan:
- f_req, f_addr = 0x01_1234; bridge returns io_ready with 0xAAAA, then 0x5555 -> io_load = io_code_seg = 1, io_addr = 0x011234; f_rdata = 0xAAAA5555; f_ack for 1 cycle, one cycle after the 2nd ready; io_load = 0 in the final-ready cycle.
- d_req, d_we = 1, d_stack = 1, d_addr = 0x02_0010, d_wdata = 0xBEEF -> io_store = io_stack_seg = 1, io_data = 0xBEEF; one io_ready -> d_ack; d_rdata unchanged.
- f_req and d_req both high from reset, each re-requesting immediately after its ack -> grants alternate FETCH, DATA, FETCH, DATA; each grant is separated by one GAP cycle with all io_* = 0.
- TIMEOUT = 8, d_req load with no io_ready -> after 8 busy cycles io_load drops; d_ack = err = 1 in the same cycle; then IDLE.
- rst pulsed after the 1st fetch beat -> all outputs 0 immediately; no f_ack; the next f_req runs both beats normally.
- io_ready pulses with no request pending -> no state change, no ack, read data registers unchanged.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one byte-serial IO bridge between the fetch unit and
// the load/store unit; latches the winner's command and guards it with a watchdog.
module io_bus_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int TCW     = 11
) (
  input  logic        clk,
  input  logic        rst,
  // Requester handshake: req is raised with its command and held until the
  // one-cycle ack; the command is sampled only at grant, so later changes (or a
  // dropped req) do not affect a running transaction. req still high in IDLE
  // after the ack is taken as a new request.
  input  logic        f_req,
  input  logic [23:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_stack,
  input  logic        d_awb,
  input  logic [23:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        err,
  output logic        io_load,
  output logic        io_store,
  output logic        io_code_seg,
  output logic        io_data_seg,
  output logic        io_stack_seg,
  output logic        io_awb,
  output logic [23:0] io_addr,
  output logic [15:0] io_data,
  input  logic        io_ready,
  input  logic [15:0] io_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam bit             TO_EN   = (TIMEOUT > 0);
  localparam logic [TCW-1:0] TO_LAST = (TIMEOUT > 0) ? TCW'(TIMEOUT - 1) : '0;

  state_t         r_state;
  logic           r_last_data;
  logic           r_beat;
  logic [TCW-1:0] r_tcnt;
  logic           r_load;
  logic           r_store;
  logic           r_code_seg;
  logic           r_data_seg;
  logic           r_stack_seg;
  logic           r_awb;
  logic [23:0]    r_addr;
  logic [15:0]    r_wdata;
  logic           r_f_ack;
  logic           r_d_ack;
  logic           r_err;
  logic [31:0]    r_f_rdata;
  logic [15:0]    r_d_rdata;

  logic w_busy;
  logic w_last_beat;
  logic w_done;
  logic w_abort;
  logic w_grant_f;
  logic w_grant_d;

  assign w_busy      = (r_state == ST_FETCH) || (r_state == ST_DATA);
  assign w_last_beat = (r_state == ST_DATA) || ((r_state == ST_FETCH) && r_beat);
  assign w_done      = io_ready & w_last_beat;
  // A ready in the expiry cycle takes precedence over the abort.
  assign w_abort     = TO_EN && w_busy && !io_ready && (r_tcnt == TO_LAST);
  assign w_grant_f   = (r_state == ST_IDLE) && f_req && (!d_req || r_last_data);
  assign w_grant_d   = (r_state == ST_IDLE) && d_req && !w_grant_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last_data <= 1'b1;
      r_beat      <= 1'b0;
      r_tcnt      <= '0;
      r_load      <= 1'b0;
      r_store     <= 1'b0;
      r_code_seg  <= 1'b0;
      r_data_seg  <= 1'b0;
      r_stack_seg <= 1'b0;
      r_awb       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_f_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_err       <= 1'b0;
      r_f_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_f_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_f || w_grant_d) begin
            r_state     <= w_grant_f ? ST_FETCH : ST_DATA;
            r_last_data <= w_grant_d;
            r_beat      <= 1'b0;
            r_tcnt      <= '0;
            r_addr      <= w_grant_f ? f_addr : d_addr;
            r_wdata     <= w_grant_f ? 16'h0000 : d_wdata;
            r_load      <= w_grant_f | ~d_we;
            r_store     <= w_grant_d & d_we;
            r_code_seg  <= w_grant_f;
            r_data_seg  <= w_grant_d & ~d_stack;
            r_stack_seg <= w_grant_d & d_stack;
            r_awb       <= w_grant_d & d_awb;
          end
        end
        ST_FETCH, ST_DATA: begin
          if (io_ready) begin
            r_tcnt <= '0;
            if (r_state == ST_FETCH) begin
              if (r_beat) begin
                r_f_rdata[15:0] <= io_rdata;
              end else begin
                r_f_rdata[31:16] <= io_rdata;
                r_beat           <= 1'b1;
              end
            end else if (r_load) begin
              r_d_rdata <= io_rdata;
            end
          end else begin
            r_tcnt <= r_tcnt + TCW'(1);
          end
          // Completion and abort both leave the bridge idle for the ack cycle.
          if (w_done || w_abort) begin
            r_state     <= ST_GAP;
            r_load      <= 1'b0;
            r_store     <= 1'b0;
            r_code_seg  <= 1'b0;
            r_data_seg  <= 1'b0;
            r_stack_seg <= 1'b0;
            r_awb       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_f_ack     <= (r_state == ST_FETCH);
            r_d_ack     <= (r_state == ST_DATA);
            r_err       <= w_abort;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_load      = r_load & ~w_done;
  assign io_store     = r_store & ~w_done;
  assign io_code_seg  = r_code_seg;
  assign io_data_seg  = r_data_seg;
  assign io_stack_seg = r_stack_seg;
  assign io_awb       = r_awb;
  assign io_addr      = r_addr;
  assign io_data      = r_wdata;
  assign f_ack        = r_f_ack;
  assign d_ack        = r_d_ack;
  assign err          = r_err;
  assign f_rdata      = r_f_rdata;
  assign d_rdata      = r_d_rdata;
  assign dbg_state    = r_state;

endmodule
